usb_tx_line_encoder: RTL and testbench
======================================

Name: usb_tx_line_encoder

Overview:
- Downstream stage of the host's USB packet encoder.
- Consumes a raw, LSB-first bit stream for one packet (PID through CRC) and drives the D+/D- bus to the thumb drive.
- Prepends SYNC, applies bit stuffing and NRZI encoding, and appends EOP (SE0, SE0, J).
- One clock cycle equals one USB bit time.

Parameters:
- SYNC_BITS, 8, number of raw SYNC bits (pattern 0000_0001, sent first bit first).
- STUFF_LIMIT, 6, consecutive raw 1s that force insertion of a stuffed 0.
- EOP_SE0_CYCLES, 2, number of SE0 bit times in EOP.

Ports:
- clk  input  1  bit-rate clock.
- rst_L  input  1  reset; asynchronous, active-low.
- pkt_start  input  1  one-cycle request to begin a packet; honoured only in IDLE.
- bit_valid  input  1  upstream has a raw bit on bit_in.
- bit_in  input  1  raw (un-stuffed, un-NRZI'd) packet bit.
- bit_last  input  1  qualifies bit_in as the final packet bit.
- bit_ready  output  1  block accepts bit_in this cycle.
- dp  output  1  D+ line, registered.
- dm  output  1  D- line, registered.
- busy  output  1  high from the cycle after accepted pkt_start until EOP J completes.
- pkt_done  output  1  one-cycle pulse on the final EOP J cycle of a normal packet.
- underrun_err  output  1  one-cycle pulse when the packet is aborted for underrun.

Behaviour:
- Reset (rst_L low, asynchronous): dp=1, dm=0 (J), busy=0, bit_ready=0, pkt_done=0, underrun_err=0, state=IDLE, ones counter=0, NRZI level=J. Reset mid-packet abandons the packet immediately; no EOP is sent.
- Line states: J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0. dp=dm=1 is never driven.
- NRZI: a raw 0 toggles J<->K; a raw 1 holds the current level. The level is J on entry to SYNC.
- States:
  - IDLE: drive J. On pkt_start go to SYNC.
  - SYNC: SYNC_BITS cycles, emitting pattern 0000_0001, so the line shows KJKJKJKK. The final 1 sets the ones counter to 1, because stuffing covers SYNC. Then go to DATA.
  - DATA: bit_ready=1. On bit_valid&&bit_ready, emit NRZI(bit_in). A 1 increments the ones counter; a 0 clears it.
    - If the counter reaches STUFF_LIMIT, go to STUFF.
    - Else, if bit_last, go to EOP.
    - An accepted bit appears on dp/dm the next cycle.
  - STUFF: bit_ready=0. Emit a stuffed 0 (toggle) and clear the counter. Then go to EOP if the preceding bit had bit_last, otherwise return to DATA. A stuff bit is always inserted, even after the last data bit.
  - EOP: EOP_SE0_CYCLES cycles of SE0, then go to EOP_J.
  - EOP_J: drive J for one cycle. Pulse pkt_done, unless the packet was aborted. Return to IDLE.
- Underrun: bit_valid=0 in DATA aborts the packet. Pulse underrun_err, go to EOP, and suppress pkt_done.
- pkt_start outside IDLE is ignored. bit_valid outside DATA is ignored.
- Latency: pkt_start in cycle t gives the first SYNC K in cycle t+1. Total line cycles = 8 + N data bits + stuff bits + 3.
- The ones counter is 3 bits and saturates at STUFF_LIMIT; it cannot wrap.

Decomposition:
- Package usb_pkg holds:
  - enum line_state_t {J, K, SE0};
  - enum tx_state_t {IDLE, SYNC, DATA, STUFF, EOP, EOP_J};
  - constant SYNC_PATTERN = 8'h80 (LSB-first).
  - constants STUFF_LIMIT and EOP_SE0_CYCLES.
- Sub-module usb_nrzi_enc holds the level register and the toggle-on-0 logic, and maps line_state_t to dp/dm.

Test Plan:
- Reset: hold rst_L low -> dp=1, dm=0, busy=0, bit_ready=0. Assert rst_L low mid-DATA -> line returns to J in the same cycle, then a new pkt_start works normally.
- pkt_start, then byte 0x00 (8 zeros, bit_last on the 8th) -> line shows KJKJKJKK JKJKJKJK SE0 SE0 J. pkt_done pulses on the J cycle; 19 cycles total.
- Byte 0xFF -> bit_ready drops for one cycle after the 5th data 1 (SYNC's 1 makes a run of 6). A stuffed 0 toggles the line. Data phase lasts 9 cycles.
- Byte 0xFC (bits 0,0,1,1,1,1,1,1) -> a stuff toggle is inserted after the last bit, before SE0. Data phase lasts 9 cycles.
- Deassert bit_valid after 3 accepted bits -> underrun_err pulses once, then SE0 SE0 J. pkt_done stays 0.
- Pulse pkt_start again while busy -> no effect on line sequence or cycle count.

Source files
------------

// File: rtl/usb_tx_line_encoder_pkg.sv
// Shared types and constants for the USB transmit line encoder.
package usb_pkg;

  localparam int          SYNC_BITS      = 8;
  localparam logic [2:0]  SYNC_LAST      = 3'(SYNC_BITS - 1);
  localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
  localparam logic [2:0]  STUFF_LIMIT    = 3'd6;
  localparam logic [1:0]  EOP_SE0_CYCLES = 2'd2;

  typedef enum logic [1:0] {J, K, SE0} line_state_t;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP, EOP_J} tx_state_t;

  typedef enum logic [1:0] {OP_J, OP_BIT, OP_SE0} nrzi_op_t;

  // Ones-run counter step; saturates so it can never wrap past the stuff point.
  function automatic logic [2:0] ones_next(input logic [2:0] cnt, input logic b);
    if (!b) return 3'd0;
    return (cnt >= STUFF_LIMIT) ? STUFF_LIMIT : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/usb_tx_line_encoder_nrzi.sv
// NRZI level register and registered D+/D- drivers; one cycle from op to line.
// OP_J forces the idle level, OP_BIT toggles on a raw 0, OP_SE0 drives SE0.
module usb_nrzi_enc
  import usb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_L,
  input  nrzi_op_t op,
  input  logic     raw_bit,
  output logic     dp,
  output logic     dm
);

  line_state_t level_q, level_d;
  line_state_t line;
  logic        dp_q, dp_d;
  logic        dm_q, dm_d;

  always_comb begin
    level_d = level_q;
    line    = J;
    case (op)
      OP_J: begin
        level_d = J;
        line    = J;
      end
      OP_BIT: begin
        if (!raw_bit) level_d = (level_q == J) ? K : J;
        line = level_d;
      end
      OP_SE0:  line = SE0;
      default: line = J;
    endcase
    dp_d = (line == J);
    dm_d = (line == K);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      level_q <= J;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
    end
  end

  assign dp = dp_q;
  assign dm = dm_q;

endmodule

// File: rtl/usb_tx_line_encoder.sv
// Packet framer: SYNC, bit stuffing, NRZI and EOP; a bit accepted in DATA shows on the line next cycle.
// bit_ready is high only in DATA; missing data there aborts the packet with an underrun.
module usb_tx_line_encoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_L,
  input  logic pkt_start,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic bit_last,
  output logic bit_ready,
  output logic dp,
  output logic dm,
  output logic busy,
  output logic pkt_done,
  output logic underrun_err
);

  tx_state_t  state_q, state_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [1:0] eop_cnt_q, eop_cnt_d;
  logic       last_q, last_d;
  logic       abort_q, abort_d;
  logic       busy_q, busy_d;
  logic       pkt_done_q, pkt_done_d;
  logic       underrun_q, underrun_d;
  nrzi_op_t   op;
  logic       raw_bit;

  // The state names the phase whose symbol is driven onto the line at the next edge.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    ones_d     = ones_q;
    eop_cnt_d  = eop_cnt_q;
    last_d     = last_q;
    abort_d    = abort_q;
    busy_d     = 1'b1;
    pkt_done_d = 1'b0;
    underrun_d = 1'b0;
    op         = OP_J;
    raw_bit    = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d    = pkt_start;
        abort_d   = 1'b0;
        last_d    = 1'b0;
        eop_cnt_d = 2'd0;
        ones_d    = 3'd0;
        if (pkt_start) begin
          op         = OP_BIT;
          raw_bit    = SYNC_PATTERN[0];
          ones_d     = ones_next(3'd0, SYNC_PATTERN[0]);
          sync_cnt_d = 3'd1;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        op         = OP_BIT;
        raw_bit    = SYNC_PATTERN[sync_cnt_q];
        ones_d     = ones_next(ones_q, raw_bit);
        sync_cnt_d = sync_cnt_q + 3'd1;
        if (sync_cnt_q == SYNC_LAST) state_d = DATA;
      end
      DATA: begin
        if (bit_valid) begin
          op      = OP_BIT;
          raw_bit = bit_in;
          ones_d  = ones_next(ones_q, bit_in);
          last_d  = bit_last;
          if (ones_d == STUFF_LIMIT) state_d = STUFF;
          else if (bit_last)         state_d = EOP;
        end else begin
          // Underrun: the first SE0 goes out immediately instead of a bogus bit.
          op         = OP_SE0;
          underrun_d = 1'b1;
          abort_d    = 1'b1;
          eop_cnt_d  = 2'd1;
          state_d    = (EOP_SE0_CYCLES == 2'd1) ? EOP_J : EOP;
        end
      end
      STUFF: begin
        op      = OP_BIT;
        raw_bit = 1'b0;
        ones_d  = 3'd0;
        state_d = last_q ? EOP : DATA;
      end
      EOP: begin
        op        = OP_SE0;
        eop_cnt_d = eop_cnt_q + 2'd1;
        if (eop_cnt_d == EOP_SE0_CYCLES) state_d = EOP_J;
      end
      EOP_J: begin
        op         = OP_J;
        pkt_done_d = !abort_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= IDLE;
      sync_cnt_q <= 3'd0;
      ones_q     <= 3'd0;
      eop_cnt_q  <= 2'd0;
      last_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      ones_q     <= ones_d;
      eop_cnt_q  <= eop_cnt_d;
      last_q     <= last_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      underrun_q <= underrun_d;
    end
  end

  usb_nrzi_enc u_nrzi (
    .clk     (clk),
    .rst_L   (rst_L),
    .op      (op),
    .raw_bit (raw_bit),
    .dp      (dp),
    .dm      (dm)
  );

  assign bit_ready    = (state_q == DATA);
  assign busy         = busy_q;
  assign pkt_done     = pkt_done_q;
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Bench for usb_tx_line_encoder: table of packets plus random packets against a symbol-list model.
module tb_usb_tx_line_encoder;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic pkt_start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, bit_last = 1'b0;
  logic bit_ready, dp, dm, busy, pkt_done, underrun_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usb_tx_line_encoder dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .pkt_start    (pkt_start),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .bit_last     (bit_last),
    .bit_ready    (bit_ready),
    .dp           (dp),
    .dm           (dm),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .underrun_err (underrun_err)
  );

  localparam int K_SYNC = 0, K_DATA = 1, K_STUFF = 2, K_UND = 3, K_SE0 = 4, K_J = 5;

  // Model output: symbol i is on the line in cycle i+1 after the pkt_start cycle.
  int         m_kind [64];
  logic [1:0] m_line [64];
  int         m_total;

  typedef struct {
    logic [31:0] data;
    int          n;
    int          ua;
    int          xs;
    int          exp_total;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_model(input logic [31:0] data, input int n, input int ua);
    int raw[$];
    int kind[$];
    int ones = 0;
    int nacc;
    bit lvl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raw.push_back(i == 7 ? 1 : 0);
      kind.push_back(K_SYNC);
      ones = (i == 7) ? ones + 1 : 0;
    end
    nacc = (ua >= 0) ? ua : n;
    for (int j = 0; j < nacc; j++) begin
      raw.push_back(int'(data[j]));
      kind.push_back(K_DATA);
      ones = data[j] ? ones + 1 : 0;
      if (ones == 6) begin
        raw.push_back(0);
        kind.push_back(K_STUFF);
        ones = 0;
      end
    end
    foreach (raw[i]) begin
      if (raw[i] == 0) lvl = !lvl;
      m_line[i] = lvl ? 2'b10 : 2'b01;
      m_kind[i] = kind[i];
    end
    m_total = raw.size();
    for (int i = 0; i < 3; i++) begin
      m_kind[m_total] = (i == 2) ? K_J : ((i == 0 && ua >= 0) ? K_UND : K_SE0);
      m_line[m_total] = (i == 2) ? 2'b10 : 2'b00;
      m_total++;
    end
  endtask

  // Called at posedge+1; cycle 0 is the pkt_start cycle.
  task automatic run_packet(input logic [31:0] data, input int n, input int ua, input int xs,
                            output int bcnt, output int dcnt, output int ecnt);
    int acc = 0;
    build_model(data, n, ua);
    bcnt = 0; dcnt = 0; ecnt = 0;
    for (int c = 0; c <= m_total + 1; c++) begin
      pkt_start = (c == 0) || (c == xs);
      bit_valid = (ua < 0) || (acc < ua);
      bit_in    = (acc < n) ? data[acc] : 1'b0;
      bit_last  = (acc == n - 1);
      @(negedge clk);
      chk($sformatf("line c%0d", c), {dp, dm}, (c == 0 || c > m_total) ? 2'b10 : m_line[c-1]);
      chk($sformatf("busy c%0d", c), busy, (c >= 1 && c <= m_total));
      chk($sformatf("ready c%0d", c), bit_ready,
          (c < m_total) && (m_kind[c] == K_DATA || m_kind[c] == K_UND));
      chk($sformatf("done c%0d", c), pkt_done, (c == m_total) && (ua < 0));
      chk($sformatf("uerr c%0d", c), underrun_err,
          (c >= 1) && (c <= m_total) && (m_kind[c-1] == K_UND));
      bcnt += int'(busy);
      dcnt += int'(pkt_done);
      ecnt += int'(underrun_err);
      if (bit_ready && bit_valid) acc++;
      @(posedge clk);
      #1;
    end
    pkt_start = 1'b0;
    bit_valid = 1'b0;
    bit_last  = 1'b0;
  endtask

  initial begin
    int bc, dc, ec;
    logic [31:0] rd;
    int rn, rua, rxs;

    tbl[0] = '{32'h00,   8, -1, -1, 19, 1, 0};
    tbl[1] = '{32'hFF,   8, -1, -1, 20, 1, 0};
    tbl[2] = '{32'hFC,   8, -1, -1, 20, 1, 0};
    tbl[3] = '{32'hA5,   8,  3, -1, 14, 0, 1};
    tbl[4] = '{32'h00,   8, -1,  5, 19, 1, 0};
    tbl[5] = '{32'hFFFF, 16, -1, -1, 29, 1, 0};
    tbl[6] = '{32'h01,   1,  0, -1, 11, 0, 1};

    // Reset held: J on the line, everything idle, pkt_start ignored.
    pkt_start = 1'b1;
    #12;
    chk("rst dp", dp, 1);
    chk("rst dm", dm, 0);
    chk("rst busy", busy, 0);
    chk("rst ready", bit_ready, 0);
    chk("rst done", pkt_done, 0);
    chk("rst uerr", underrun_err, 0);
    pkt_start = 1'b0;
    rst_L = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_packet(tbl[i].data, tbl[i].n, tbl[i].ua, tbl[i].xs, bc, dc, ec);
      chk($sformatf("tbl%0d cycles", i), bc, tbl[i].exp_total);
      chk($sformatf("tbl%0d done pulses", i), dc, tbl[i].exp_done);
      chk($sformatf("tbl%0d uerr pulses", i), ec, tbl[i].exp_err);
    end

    // Asynchronous reset in the middle of DATA, then a normal packet.
    pkt_start = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    bit_last  = 1'b0;
    @(posedge clk);
    #1;
    pkt_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid line K", {dp, dm}, 2'b01);
    chk("mid busy", busy, 1);
    rst_L = 1'b0;
    #1;
    chk("mid rst line J", {dp, dm}, 2'b10);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", bit_ready, 0);
    bit_valid = 1'b0;
    #3;
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    run_packet(32'h00, 8, -1, -1, bc, dc, ec);
    chk("post rst cycles", bc, 19);
    chk("post rst done", dc, 1);

    for (int r = 0; r < 30; r++) begin
      rn  = $urandom_range(1, 24);
      rd  = (r % 2 == 0) ? ($urandom | $urandom) : $urandom;
      rua = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
      rxs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
      run_packet(rd, rn, rua, rxs, bc, dc, ec);
      chk($sformatf("rnd%0d cycles", r), bc, m_total);
      chk($sformatf("rnd%0d done pulses", r), dc, (rua < 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
